vc_fifo_arbiter: RTL and testbench

- Round-robin arbiter that drains four virtual-channel input FIFOs (fifo instances, 1-cycle registered read latency) into a single shared word path.
- Each word is steered to one of four destination FIFOs, selected by the word's two MSBs.
- Applies global back-pressure: no new pops while any destination is almost full or full.
- Sits between the input VC FIFO bank and the output FIFO bank of the transaction layer.

---
 rtl/vc_arb_pkg.sv | 30 +++
 rtl/rr_picker.sv | 36 +++
 rtl/vc_fifo_arbiter.sv | 126 ++++++++++++
 tb/tb_vc_fifo_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vc_arb_pkg.sv
// ============================================================================
// Module   : vc_arb_pkg
// Brief    : Shared encodings and constants for the VC FIFO arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vc_arb_pkg;

  localparam int NUM_VC = 4;
  localparam int DEST_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  function automatic logic [DEST_W-1:0] oh2idx(input logic [NUM_VC-1:0] oh);
    logic [DEST_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (oh[i]) idx = DEST_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational 4-way rotate-priority picker; ptr has top priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_picker
  import vc_arb_pkg::*;
(
  input  logic [NUM_VC-1:0] eligible,
  input  logic [DEST_W-1:0] ptr,
  output logic [NUM_VC-1:0] grant,
  output logic              valid
);

  logic [DEST_W-1:0] w_idx;

  // Walk from the farthest offset down so the entry nearest ptr overrides.
  always_comb begin
    grant = '0;
    w_idx = '0;
    for (int k = NUM_VC - 1; k >= 0; k--) begin
      w_idx = ptr + DEST_W'(k);
      if (eligible[w_idx]) begin
        grant        = '0;
        grant[w_idx] = 1'b1;
      end
    end
  end

  assign valid = |eligible;

endmodule

`default_nettype wire

// File: rtl/vc_fifo_arbiter.sv
// ============================================================================
// Module   : vc_fifo_arbiter
// Brief    : Drains four VC FIFOs into four destination FIFOs, 2-cycle pop-to-
//            push pipeline, global pause. ARB_STRICT_PRIORITY_EN: fixed VC0-first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vc_fifo_arbiter #(
  parameter int BITNUMBER = 8,
  parameter int NUM_VC    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_VC*BITNUMBER-1:0] vc_data_in,
  input  logic [NUM_VC-1:0]           vc_empty,
  input  logic [NUM_VC-1:0]           vc_almost_empty,
  output logic [NUM_VC-1:0]           vc_pop,
  input  logic [NUM_VC-1:0]           dst_full,
  input  logic [NUM_VC-1:0]           dst_almost_full,
  output logic [NUM_VC-1:0]           dst_push,
  output logic [BITNUMBER-1:0]        dst_data,
  output logic [1:0]                  state,
  output logic                        idle
);

  import vc_arb_pkg::*;

  state_t               r_state;
  state_t               w_next;
  logic [DEST_W-1:0]    w_ptr;
  logic [NUM_VC-1:0]    w_eligible;
  logic [NUM_VC-1:0]    w_grant;
  logic                 w_pick_valid;
  logic                 w_pause;
  logic                 w_do_pop;
  logic                 r_rd_valid;
  logic [NUM_VC-1:0]    r_rd_sel;
  logic [BITNUMBER-1:0] w_rd_word;
  logic [NUM_VC-1:0]    w_dest_oh;

  // A FIFO popped this cycle whose flags still say "one left" is really empty.
  assign w_eligible = ~vc_empty & ~(vc_pop & vc_almost_empty);
  assign w_pause    = |(dst_almost_full | dst_full);

  rr_picker u_picker (
    .eligible (w_eligible),
    .ptr      (w_ptr),
    .grant    (w_grant),
    .valid    (w_pick_valid)
  );

`ifdef ARB_STRICT_PRIORITY_EN
  assign w_ptr = '0;
`else
  logic [DEST_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (w_do_pop) begin
      r_ptr <= oh2idx(w_grant) + DEST_W'(1);
    end
  end

  assign w_ptr = r_ptr;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (enable && !(&vc_empty)) w_next = ST_RUN;
      ST_RUN: begin
        if (!enable)            w_next = ST_IDLE;
        else if (w_pause)       w_next = ST_PAUSE;
        else if (!w_pick_valid) w_next = ST_IDLE;
      end
      ST_PAUSE: begin
        if (!enable)            w_next = ST_IDLE;
        else if (!w_pause)      w_next = ST_RUN;
      end
      default:                  w_next = ST_IDLE;
    endcase
  end

  // The pop is registered together with the state so vc_pop is only ever high in RUN.
  assign w_do_pop = (w_next == ST_RUN) && !w_pause && w_pick_valid;

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (r_rd_sel[i]) w_rd_word = vc_data_in[i*BITNUMBER +: BITNUMBER];
    end
  end

  always_comb begin
    w_dest_oh = '0;
    w_dest_oh[w_rd_word[BITNUMBER-1 -: DEST_W]] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      vc_pop     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_sel   <= '0;
      dst_push   <= '0;
      dst_data   <= '0;
      idle       <= 1'b1;
    end else begin
      r_state    <= w_next;
      vc_pop     <= w_do_pop ? w_grant : '0;
      r_rd_valid <= |vc_pop;
      r_rd_sel   <= vc_pop;
      dst_push   <= r_rd_valid ? w_dest_oh : '0;
      if (r_rd_valid) dst_data <= w_rd_word;
      idle       <= (w_next == ST_IDLE) && !(|vc_pop);
    end
  end

  assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_vc_fifo_arbiter.sv
// ============================================================================
// Module   : tb_vc_fifo_arbiter
// Brief    : Scoreboard bench for vc_fifo_arbiter with behavioural VC FIFOs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vc_fifo_arbiter;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [4*BW-1:0] vc_data_in = '0;
  logic [3:0]    vc_empty = 4'hF;
  logic [3:0]    vc_almost_empty = 4'hF;
  logic [3:0]    vc_pop;
  logic [3:0]    dst_full = 4'h0;
  logic [3:0]    dst_almost_full = 4'h0;
  logic [3:0]    dst_push;
  logic [BW-1:0] dst_data;
  logic [1:0]    state;
  logic          idle;

  int total = 0;
  int bad = 0;

  logic [7:0] vcq [4][$];
  int         exp_pop_q [$];
  logic [7:0] exp_push_q [$];

  logic [7:0] t2 [8] = '{8'h05, 8'h46, 8'h57, 8'h98, 8'hA9, 8'hEA, 8'hFB, 8'h0C};
  logic [7:0] t4 [6] = '{8'h11, 8'h52, 8'h93, 8'hD4, 8'h15, 8'h56};
  logic [7:0] t6 [6] = '{8'h21, 8'h62, 8'hA3, 8'hE4, 8'h25, 8'h66};
`ifdef ARB_STRICT_PRIORITY_EN
  int o2 [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int o4 [6] = '{0, 1, 2, 3, 4, 5};
  int o6 [6] = '{0, 1, 2, 3, 4, 5};
`else
  int o2 [8] = '{0, 2, 4, 6, 1, 3, 5, 7};
  int o4 [6] = '{0, 3, 1, 4, 2, 5};
  int o6 [6] = '{3, 0, 4, 1, 5, 2};
`endif

  always #5 clk = ~clk;

  vc_fifo_arbiter #(.BITNUMBER(BW), .NUM_VC(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .vc_data_in      (vc_data_in),
    .vc_empty        (vc_empty),
    .vc_almost_empty (vc_almost_empty),
    .vc_pop          (vc_pop),
    .dst_full        (dst_full),
    .dst_almost_full (dst_almost_full),
    .dst_push        (dst_push),
    .dst_data        (dst_data),
    .state           (state),
    .idle            (idle)
  );

  // VC FIFO models: registered read data, flags reflect the contents after the edge.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vc_pop[i] && vcq[i].size() > 0) vc_data_in[i*BW +: BW] <= vcq[i].pop_front();
      vc_empty[i]        <= (vcq[i].size() == 0);
      vc_almost_empty[i] <= (vcq[i].size() <= 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic load(input int vc, input logic [7:0] w);
    vcq[vc].push_back(w);
  endtask

  task automatic expect_word(input int vc, input logic [7:0] w, input bit pushed);
    exp_pop_q.push_back(vc);
    if (pushed) exp_push_q.push_back(w);
  endtask

  task automatic wait_pop(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (vc_pop != 4'h0) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (exp_pop_q.size() == 0 && exp_push_q.size() == 0 && idle) done = 1'b1;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  // Monitor: every pop and push the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (vc_pop != 4'h0) begin
        if (exp_pop_q.size() == 0) chk("pop_unexpected", {28'd0, vc_pop}, 32'd0);
        else chk("pop_order", {28'd0, vc_pop}, 32'd1 << exp_pop_q.pop_front());
        chk("pop_on_empty", {28'd0, vc_pop & vc_empty}, 32'd0);
      end
      if (dst_push != 4'h0) begin
        if (exp_push_q.size() == 0) chk("push_unexpected", {28'd0, dst_push}, 32'd0);
        else begin
          logic [7:0] w;
          w = exp_push_q.pop_front();
          chk("push_dest", {28'd0, dst_push}, 32'd1 << w[7:6]);
          chk("push_data", {24'd0, dst_data}, {24'd0, w});
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pop",   {28'd0, vc_pop},   32'd0);
    chk("rst_push",  {28'd0, dst_push}, 32'd0);
    chk("rst_data",  {24'd0, dst_data}, 32'd0);
    chk("rst_state", {30'd0, state},    32'd0);
    chk("rst_idle",  {31'd0, idle},     32'd1);

    // Two words per VC, loaded while reset is held.
    for (int k = 0; k < 8; k++) load(k / 2, t2[k]);
    for (int k = 0; k < 8; k++) expect_word(o2[k] / 2, t2[o2[k]], 1'b1);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("first_pop", {28'd0, vc_pop}, 32'd1);
    repeat (2) @(negedge clk);
    chk("first_push", {28'd0, dst_push}, 32'd1);
    chk("first_data", {24'd0, dst_data}, 32'h05);
    drain("drain_t2");

    // Single word on VC2.
    load(2, 8'h8D);
    expect_word(2, 8'h8D, 1'b1);
    drain("drain_t3");

    // Pause with two words in flight.
    for (int k = 0; k < 6; k++) load(k / 3, t4[k]);
    for (int k = 0; k < 6; k++) expect_word(o4[k] / 3, t4[o4[k]], 1'b1);
    wait_pop("t4_start");
    @(negedge clk);
    chk("t4_pop_before_pause", {31'd0, vc_pop != 4'h0}, 32'd1);
    dst_almost_full = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_pause_state", {30'd0, state}, 32'd2);
      chk("t4_pause_nopop", {28'd0, vc_pop}, 32'd0);
      chk("t4_inflight_push", {31'd0, dst_push != 4'h0}, {31'd0, k < 2});
    end
    dst_almost_full = 4'b0000;
    @(negedge clk);
    chk("t4_resume_state", {30'd0, state}, 32'd1);
    chk("t4_resume_pop", {31'd0, vc_pop != 4'h0}, 32'd1);
    drain("drain_t4");

    // VC0 and VC3 both backlogged.
    for (int k = 0; k < 6; k++) load((k < 3) ? 0 : 3, t6[k]);
    for (int k = 0; k < 6; k++) expect_word((o6[k] < 3) ? 0 : 3, t6[o6[k]], 1'b1);
    drain("drain_t6");

    // Enable falls with one pop in flight.
    load(1, 8'h47); load(1, 8'h88); load(1, 8'hC9);
    expect_word(1, 8'h47, 1'b1); expect_word(1, 8'h88, 1'b1); expect_word(1, 8'hC9, 1'b1);
    wait_pop("t7_start");
    enable = 1'b0;
    @(negedge clk);
    chk("t7_state_idle", {30'd0, state}, 32'd0);
    chk("t7_no_pop", {28'd0, vc_pop}, 32'd0);
    chk("t7_idle_low", {31'd0, idle}, 32'd0);
    @(negedge clk);
    chk("t7_idle_high", {31'd0, idle}, 32'd1);
    chk("t7_push", {28'd0, dst_push}, 32'b0010);
    enable = 1'b1;
    drain("drain_t7");

    // Asynchronous reset mid-stream: word A in the read stage is lost, B's pop is cancelled.
    load(1, 8'h0A); load(1, 8'h4B);
    expect_word(1, 8'h0A, 1'b0); expect_word(1, 8'h4B, 1'b1);
    wait_pop("t5_start");
    @(posedge clk);
    #1;
    chk("t5_second_pop", {28'd0, vc_pop}, 32'b0010);
    reset = 1'b0;
    #1;
    chk("t5_async_pop",   {28'd0, vc_pop},   32'd0);
    chk("t5_async_push",  {28'd0, dst_push}, 32'd0);
    chk("t5_async_data",  {24'd0, dst_data}, 32'd0);
    chk("t5_async_state", {30'd0, state},    32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drain("drain_t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
